// File: rtl/fp_maxmin_reduce.sv
// Streaming FP max/min reduction: folds a valid/ready burst down to its
// max or min element, reporting the winner's index and a canonical-NaN flag.
// Exponent/mantissa widths are parameters so FP32/FP16/BF16 share one block.
module fp_maxmin_reduce #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int IDX_W    = 16,
  parameter int NAN_MODE = 0,
  localparam int DW      = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [DW-1:0]    i_data,
  input  logic             i_last,
  input  logic             i_is_max,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [DW-1:0]    o_res,
  output logic [IDX_W-1:0] o_res_idx,
  output logic             o_res_nan
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_e;

  localparam logic [IDX_W-1:0] IDX_MAX = '1;
  localparam logic [DW-1:0]    QNAN    = '1;

  state_e           state_q;
  logic [DW-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;   // index of the current winner
  logic [IDX_W-1:0] cnt_q;          // index of the last accepted beat
  logic [IDX_W-1:0] beat_idx;
  logic             nan_q, nan_d;   // mode 0: NaN seen; mode 1: acc holds NaN
  logic             mode_q;         // 1 = max
  logic             accept, first, is_max, in_nan, win;

  function automatic logic is_nan(input logic [DW-1:0] x);
    return (&x[DW-2 -: EXP_W]) && (|x[MAN_W-1:0]);
  endfunction

  // Sign-magnitude to monotonic unsigned key (-0 sorts just below +0).
  function automatic logic [DW-1:0] ord_key(input logic [DW-1:0] x);
    return x[DW-1] ? ~x : {1'b1, x[DW-2:0]};
  endfunction

  assign o_ready = (state_q != S_DONE);
  assign accept  = i_valid & o_ready;
  assign first   = (state_q == S_IDLE);

  // Per-beat fold: candidate accumulator/index/NaN state if this beat is taken.
  always_comb begin
    beat_idx = first ? '0 : ((cnt_q == IDX_MAX) ? cnt_q : cnt_q + 1'b1);
    is_max   = first ? i_is_max : mode_q;
    in_nan   = is_nan(i_data);
    win      = is_max ? (ord_key(i_data) > ord_key(acc_q))
                      : (ord_key(i_data) < ord_key(acc_q));
    acc_d    = acc_q;
    idx_d    = idx_q;
    nan_d    = nan_q;
    if (first) begin
      acc_d = i_data;
      idx_d = '0;
      nan_d = in_nan;
    end else if (NAN_MODE == 0) begin
      // Once a NaN is seen the result is fixed; only the first NaN's index sticks.
      if (!nan_q) begin
        if (in_nan) begin
          nan_d = 1'b1;
          idx_d = beat_idx;
        end else if (win) begin
          acc_d = i_data;
          idx_d = beat_idx;
        end
      end
    end else begin
      // NaN never wins; any number displaces a NaN accumulator.
      if (!in_nan && (nan_q || win)) begin
        acc_d = i_data;
        idx_d = beat_idx;
        nan_d = 1'b0;
      end
    end
  end

  // Control FSM with registered result outputs loaded on the final beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      mode_q      <= 1'b0;
      o_res_valid <= 1'b0;
      o_res       <= '0;
      o_res_idx   <= '0;
      o_res_nan   <= 1'b0;
    end else begin
      if (accept) begin
        acc_q <= acc_d;
        idx_q <= idx_d;
        nan_q <= nan_d;
        cnt_q <= beat_idx;
        if (first) mode_q <= i_is_max;
        if (i_last) begin
          state_q     <= S_DONE;
          o_res_valid <= 1'b1;
          o_res       <= nan_d ? QNAN : acc_d;
          o_res_idx   <= idx_d;
          o_res_nan   <= nan_d;
        end else begin
          state_q <= S_ACC;
        end
      end else if (state_q == S_DONE && i_res_ready) begin
        state_q     <= S_IDLE;
        o_res_valid <= 1'b0;
      end
    end
  end

endmodule
